vend_ctrl_param: RTL and testbench
==================================

VEND_CTRL_PARAM -- requirements
Module: vend_ctrl_param

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 4, meaning number of selectable products.
REQ-002 The block SHALL have parameter CREDIT_W, default 8, meaning width of credit, price and change values.
REQ-003 The block SHALL have parameter PRICES, default {8'd20,8'd15,8'd10,8'd5}, meaning packed NUM_ITEMS*CREDIT_W price table with item 0 in the low slice.
REQ-004 The block SHALL have parameter CREDIT_MAX, default 50, meaning the highest credit the block may hold.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have ports coin_01rs, coin_02rs, coin_05rs, coin_10rs, input, 1 bit each: one-cycle coin-insert pulses of value 1, 2, 5 and 10.
REQ-008 The block SHALL have ports sel_valid, input, 1 bit, and sel_item, input, IDX_W=$clog2(NUM_ITEMS) bits: product request.
REQ-009 The block SHALL have port cancel, input, 1 bit: refund request.
REQ-010 The block SHALL have ports vend, output, 1 bit, pulse, and vend_item, output, IDX_W bits: product dispensed.
REQ-011 The block SHALL have port change_coin, output, 4 bits: one-hot {10,5,2,1} coin ejected this cycle.
REQ-012 The block SHALL have port change_done, output, 1 bit: pulse on the last change coin.
REQ-013 The block SHALL have port credit, output, CREDIT_W bits: current held credit or remaining change.
REQ-014 The block SHALL have ports busy, coin_reject and short, output, 1 bit each: block in VEND/CHANGE; coin refused; credit insufficient.

Function
REQ-015 The state machine SHALL have states IDLE, CREDIT, VEND and CHANGE.
REQ-016 Coins asserted in one cycle SHALL be summed, and credit SHALL update on the following edge (1-cycle latency).
REQ-017 If credit plus the coin sum exceeds CREDIT_MAX, all coins of that cycle SHALL be refused, credit SHALL stay unchanged, and coin_reject SHALL pulse next cycle.
REQ-018 Coins arriving in VEND, in CHANGE, or in the same cycle as an accepted select or cancel SHALL be refused with a coin_reject pulse.
REQ-019 An accepted sel_valid in IDLE/CREDIT with sel_item < NUM_ITEMS and pre-cycle credit >= price SHALL move the block to VEND, assert vend for exactly one cycle with vend_item, and load credit with credit-price.
REQ-020 After VEND, the block SHALL enter CHANGE if the remainder is > 0, otherwise IDLE.
REQ-021 sel_valid with credit < price SHALL pulse short next cycle and leave state and credit unchanged.
REQ-022 sel_valid with sel_item >= NUM_ITEMS SHALL be ignored with no pulse.
REQ-023 cancel in CREDIT SHALL enter CHANGE with the full credit; cancel in IDLE, VEND or CHANGE SHALL be ignored; cancel SHALL win over a simultaneous sel_valid.
REQ-024 Each CHANGE cycle SHALL assert change_coin for the largest denomination <= remaining credit and subtract it.
REQ-025 change_done SHALL assert with the final coin, after which the block SHALL return to IDLE with credit 0.
REQ-026 busy SHALL be 1 exactly in VEND and CHANGE.
REQ-027 All arithmetic SHALL be unsigned CREDIT_W; CREDIT_MAX+10 SHALL fit in CREDIT_W, checked at elaboration.

Reset
REQ-028 While rst=0 at a clock edge, the block SHALL enter state IDLE and drive credit=0, vend=0, vend_item=0, change_coin=0, change_done=0, busy=0, coin_reject=0 and short=0.
REQ-029 Reset mid-CHANGE or mid-VEND SHALL abandon the operation, with no further coins or vend pulses.

Structure
REQ-030 Package vmc_pkg SHALL hold the state enum, the coin value constants 1/2/5/10, and the change_coin bit positions.
REQ-031 The greedy denomination selector SHALL be sub-module vmc_change_gen (remaining credit in, one-hot coin and its value out).

Verification
REQ-032 The bench SHALL cover: rst=0 for 2 cycles -> all outputs 0, credit=0.
REQ-033 The bench SHALL cover: coin_10rs, then sel item1 (price 10) -> vend=1 with vend_item=1, no change_coin, credit=0, IDLE.
REQ-034 The bench SHALL cover: two coin_10rs, then sel item0 (price 5) -> vend, then change_coin 10 and then 5 on consecutive cycles, with change_done on the 5.
REQ-035 The bench SHALL cover: coin_02rs twice (credit 4), sel item2 (price 15) -> short pulse, credit 4; then cancel -> change_coin 2, 2 and change_done.
REQ-036 The bench SHALL cover: credit 45 plus coin_10rs -> coin_reject, credit 45; then coin_05rs -> credit 50.
REQ-037 The bench SHALL cover: rst=0 during CHANGE with 8 remaining -> next cycle IDLE, credit 0, no further change_coin.

Source files
------------

// File: rtl/vmc_pkg.sv
// Shared types and constants for the vending controller.
package vmc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } vmc_state_e;

  // Coin denominations
  localparam int unsigned COIN_VAL_1  = 1;
  localparam int unsigned COIN_VAL_2  = 2;
  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;

  // Bit positions inside the one-hot change_coin output {10,5,2,1}
  localparam int unsigned COIN_BIT_1  = 0;
  localparam int unsigned COIN_BIT_2  = 1;
  localparam int unsigned COIN_BIT_5  = 2;
  localparam int unsigned COIN_BIT_10 = 3;

endpackage

// File: rtl/vmc_change_gen.sv
// Greedy change selector: picks the largest coin not exceeding the remainder.
module vmc_change_gen
  import vmc_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] remain_i,
  output logic [3:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  // Largest-denomination-first selection; zero remainder yields no coin
  always_comb begin
    coin_o  = '0;
    value_o = '0;
    if (remain_i >= CREDIT_W'(COIN_VAL_10)) begin
      coin_o[COIN_BIT_10] = 1'b1;
      value_o             = CREDIT_W'(COIN_VAL_10);
    end else if (remain_i >= CREDIT_W'(COIN_VAL_5)) begin
      coin_o[COIN_BIT_5] = 1'b1;
      value_o            = CREDIT_W'(COIN_VAL_5);
    end else if (remain_i >= CREDIT_W'(COIN_VAL_2)) begin
      coin_o[COIN_BIT_2] = 1'b1;
      value_o            = CREDIT_W'(COIN_VAL_2);
    end else if (remain_i >= CREDIT_W'(COIN_VAL_1)) begin
      coin_o[COIN_BIT_1] = 1'b1;
      value_o            = CREDIT_W'(COIN_VAL_1);
    end
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: coin accumulation, product vend and greedy change payout.
module vend_ctrl_param
  import vmc_pkg::*;
#(
  parameter int unsigned                     NUM_ITEMS  = 4,
  parameter int unsigned                     CREDIT_W   = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int unsigned                     CREDIT_MAX = 50,
  localparam int unsigned                    IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_01rs,
  input  logic                coin_02rs,
  input  logic                coin_05rs,
  input  logic                coin_10rs,
  input  logic                sel_valid,
  input  logic [IDX_W-1:0]    sel_item,
  input  logic                cancel,
  output logic                vend,
  output logic [IDX_W-1:0]    vend_item,
  output logic [3:0]          change_coin,
  output logic                change_done,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                short
);

  localparam int unsigned SW = CREDIT_W + 2;

  if (((64'(CREDIT_MAX) + 64'd10) >> CREDIT_W) != 64'd0) begin : g_width_check
    $error("CREDIT_MAX+10 does not fit in CREDIT_W bits");
  end

  vmc_state_e          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    item_q, item_d;
  logic                reject_q, reject_d;
  logic                short_q, short_d;

  logic [4:0]          coin_sum;
  logic                coin_any;
  logic [SW-1:0]       total;
  logic [CREDIT_W-1:0] price;
  logic                item_ok;
  logic [3:0]          gen_coin;
  logic [CREDIT_W-1:0] gen_value;

  vmc_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .remain_i (credit_q),
    .coin_o   (gen_coin),
    .value_o  (gen_value)
  );

  // Sum of coins inserted this cycle and the resulting tentative credit
  always_comb begin
    coin_sum = '0;
    if (coin_01rs) coin_sum = coin_sum + 5'(COIN_VAL_1);
    if (coin_02rs) coin_sum = coin_sum + 5'(COIN_VAL_2);
    if (coin_05rs) coin_sum = coin_sum + 5'(COIN_VAL_5);
    if (coin_10rs) coin_sum = coin_sum + 5'(COIN_VAL_10);
    coin_any = coin_01rs | coin_02rs | coin_05rs | coin_10rs;
    total    = SW'(credit_q) + SW'(coin_sum);
  end

  // Price lookup; out-of-range selections leave item_ok low
  always_comb begin
    price   = '0;
    item_ok = 1'b0;
    for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
      if (sel_item == IDX_W'(i)) begin
        item_ok = 1'b1;
        price   = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
  end

  // State, credit and pulse registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      reject_q <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      item_q   <= item_d;
      reject_q <= reject_d;
      short_q  <= short_d;
    end
  end

  // Next-state logic: cancel beats select, select beats coins
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    item_d   = item_q;
    reject_d = 1'b0;
    short_d  = 1'b0;
    unique case (state_q)
      IDLE, CREDIT: begin
        if (cancel && (state_q == CREDIT)) begin
          state_d  = CHANGE;
          reject_d = coin_any;
        end else if (sel_valid && item_ok && (credit_q >= price)) begin
          state_d  = VEND;
          credit_d = credit_q - price;
          item_d   = sel_item;
          reject_d = coin_any;
        end else begin
          short_d = sel_valid && item_ok;
          if (coin_any) begin
            if (total > SW'(CREDIT_MAX)) begin
              reject_d = 1'b1;
            end else begin
              credit_d = total[CREDIT_W-1:0];
              state_d  = CREDIT;
            end
          end
        end
      end
      VEND: begin
        reject_d = coin_any;
        state_d  = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_any;
        credit_d = credit_q - gen_value;
        if (credit_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    vend        = (state_q == VEND);
    vend_item   = vend ? item_q : '0;
    busy        = (state_q == VEND) || (state_q == CHANGE);
    change_coin = (state_q == CHANGE) ? gen_coin : '0;
    change_done = (state_q == CHANGE) && (credit_q == gen_value);
    credit      = credit_q;
    coin_reject = reject_q;
    short       = short_q;
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed scoreboard bench for vend_ctrl_param with default parameters.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst, coin_01rs, coin_02rs, coin_05rs, coin_10rs;
  logic       sel_valid, cancel;
  logic [1:0] sel_item;
  logic       vend, change_done, busy, coin_reject, short;
  logic [1:0] vend_item;
  logic [3:0] change_coin;
  logic [7:0] credit;

  always #5 clk = ~clk;

  vend_ctrl_param #(
    .NUM_ITEMS  (4),
    .CREDIT_W   (8),
    .PRICES     ({8'd20, 8'd15, 8'd10, 8'd5}),
    .CREDIT_MAX (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_01rs   (coin_01rs),
    .coin_02rs   (coin_02rs),
    .coin_05rs   (coin_05rs),
    .coin_10rs   (coin_10rs),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .vend        (vend),
    .vend_item   (vend_item),
    .change_coin (change_coin),
    .change_done (change_done),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .short       (short)
  );

  typedef struct packed {
    logic       vend;
    logic [1:0] item;
    logic [3:0] cc;
    logic       done;
    logic [7:0] credit;
    logic       busy;
    logic       rej;
    logic       shrt;
  } obs_t;

  // Coin encodings {10,5,2,1}, shared by coin inputs and change_coin
  localparam logic [3:0] N   = 4'b0000;
  localparam logic [3:0] K1  = 4'b0001;
  localparam logic [3:0] K2  = 4'b0010;
  localparam logic [3:0] K5  = 4'b0100;
  localparam logic [3:0] K10 = 4'b1000;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t mk(input logic v, input logic [1:0] it, input logic [3:0] cc,
                              input logic dn, input logic [7:0] cr, input logic bz,
                              input logic rj, input logic sh);
    obs_t o;
    o.vend = v; o.item = it; o.cc = cc; o.done = dn;
    o.credit = cr; o.busy = bz; o.rej = rj; o.shrt = sh;
    return o;
  endfunction

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outcome, then compare after the edge
  task automatic step(input string tag, input logic [3:0] coins, input logic sv,
                      input logic [1:0] si, input logic cn, input logic rs, input obs_t exp);
    obs_t e;
    @(negedge clk);
    {coin_10rs, coin_05rs, coin_02rs, coin_01rs} = coins;
    sel_valid = sv;
    sel_item  = si;
    cancel    = cn;
    rst       = rs;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(tag, "vend",        32'(vend),        32'(e.vend));
    chk(tag, "vend_item",   32'(vend_item),   32'(e.item));
    chk(tag, "change_coin", 32'(change_coin), 32'(e.cc));
    chk(tag, "change_done", 32'(change_done), 32'(e.done));
    chk(tag, "credit",      32'(credit),      32'(e.credit));
    chk(tag, "busy",        32'(busy),        32'(e.busy));
    chk(tag, "coin_reject", 32'(coin_reject), 32'(e.rej));
    chk(tag, "short",       32'(short),       32'(e.shrt));
  endtask

  initial begin
    obs_t z;
    z = mk(0, 0, N, 0, 8'd0, 0, 0, 0);
    rst = 1'b0; coin_01rs = 1'b0; coin_02rs = 1'b0; coin_05rs = 1'b0; coin_10rs = 1'b0;
    sel_valid = 1'b0; sel_item = 2'd0; cancel = 1'b0;

    // Reset held two cycles
    step("rst0", N, 0, 0, 0, 0, z);
    step("rst1", N, 0, 0, 0, 0, z);

    // Exact-price vend; a coin in the select cycle is refused
    step("v1_coin", K10, 0, 0, 0, 1, mk(0, 0, N, 0, 8'd10, 0, 0, 0));
    step("v1_sel",  K1,  1, 1, 0, 1, mk(1, 1, N, 0, 8'd0,  1, 1, 0));
    step("v1_idle", N,   0, 0, 0, 1, z);
    step("v1_hold", N,   0, 0, 0, 1, z);

    // Vend with change 15 -> 10 then 5
    step("v2_c1",  K10, 0, 0, 0, 1, mk(0, 0, N,   0, 8'd10, 0, 0, 0));
    step("v2_c2",  K10, 0, 0, 0, 1, mk(0, 0, N,   0, 8'd20, 0, 0, 0));
    step("v2_sel", N,   1, 0, 0, 1, mk(1, 0, N,   0, 8'd15, 1, 0, 0));
    step("v2_ch1", N,   0, 0, 0, 1, mk(0, 0, K10, 0, 8'd15, 1, 0, 0));
    step("v2_ch2", N,   0, 0, 0, 1, mk(0, 0, K5,  1, 8'd5,  1, 0, 0));
    step("v2_end", N,   0, 0, 0, 1, z);

    // Insufficient credit, then cancel refund 2+2
    step("s_c1",   K2, 0, 0, 0, 1, mk(0, 0, N,  0, 8'd2, 0, 0, 0));
    step("s_c2",   K2, 0, 0, 0, 1, mk(0, 0, N,  0, 8'd4, 0, 0, 0));
    step("s_sel",  N,  1, 2, 0, 1, mk(0, 0, N,  0, 8'd4, 0, 0, 1));
    step("s_can",  N,  0, 0, 1, 1, mk(0, 0, K2, 0, 8'd4, 1, 0, 0));
    step("s_ch2",  N,  0, 0, 0, 1, mk(0, 0, K2, 1, 8'd2, 1, 0, 0));
    step("s_end",  N,  0, 0, 0, 1, z);

    // Credit ceiling: 45+10 refused, 45+5 reaches 50, 50+1 refused
    for (int i = 1; i <= 4; i++)
      step("m_fill", K10, 0, 0, 0, 1, mk(0, 0, N, 0, 8'(10 * i), 0, 0, 0));
    step("m_45",   K5,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd45, 0, 0, 0));
    step("m_rej",  K10, 0, 0, 0, 1, mk(0, 0, N, 0, 8'd45, 0, 1, 0));
    step("m_50",   K5,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd50, 0, 0, 0));
    step("m_rej1", K1,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd50, 0, 1, 0));
    step("m_can",  N,   0, 0, 1, 1, mk(0, 0, K10, 0, 8'd50, 1, 0, 0));
    for (int r = 40; r >= 10; r -= 10)
      step("m_ch", N, 0, 0, 0, 1, mk(0, 0, K10, (r == 10), 8'(r), 1, 0, 0));
    step("m_end",  N,   0, 0, 0, 1, z);

    // Reset mid-CHANGE with 8 remaining abandons payout
    step("r_c10", K10, 0, 0, 0, 1, mk(0, 0, N, 0, 8'd10, 0, 0, 0));
    step("r_c5",  K5,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd15, 0, 0, 0));
    step("r_c2",  K2,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd17, 0, 0, 0));
    step("r_c1",  K1,  0, 0, 0, 1, mk(0, 0, N, 0, 8'd18, 0, 0, 0));
    step("r_can", N,   0, 0, 1, 1, mk(0, 0, K10, 0, 8'd18, 1, 0, 0));
    step("r_ch",  N,   0, 0, 0, 1, mk(0, 0, K5,  0, 8'd8,  1, 0, 0));
    step("r_rst", N,   0, 0, 0, 0, z);
    step("r_aft", N,   0, 0, 0, 1, z);
    step("r_aft", N,   0, 0, 0, 1, z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
